factorial_arbiter: RTL and testbench

FACTORIAL_ARBITER -- requirements
Module: factorial_arbiter

---
 rtl/factorial_arbiter.sv | 132 +++++++++++++
 tb/tb_factorial_arbiter.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/factorial_arbiter.sv
// Round-robin arbiter sharing one factorial engine among NREQ requesters, guarded by a watchdog.
// Grant->rsp_valid is n+5 cycles via the engine, 1 cycle for n<2; one request in flight, req_ready only in IDLE.
module factorial_arbiter #(
  parameter int NREQ       = 4,
  parameter int WDOG_LIMIT = 24
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NREQ-1:0]         req_valid,
  input  logic [NREQ*4-1:0]       req_data,
  output logic [NREQ-1:0]         req_ready,
  output logic                    rsp_valid,
  output logic [$clog2(NREQ)-1:0] rsp_id,
  output logic [45:0]             rsp_data,
  output logic                    rsp_err,
  output logic [3:0]              eng_in_data,
  output logic                    eng_in_valid,
  input  logic [45:0]             eng_out_data,
  input  logic                    eng_out_valid,
  input  logic                    eng_out_busy
);
  localparam int IDW = $clog2(NREQ);

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT_BUSY, WAIT_DONE, RESP} state_t;

  state_t         state, state_nxt;
  logic [IDW-1:0] last_grant, id_q, grant_id, cand;
  logic           grant_any;
  logic [3:0]     grant_n, n_q;
  logic [4:0]     wdog;
  logic           done, timeout;

  // Search starts just after the last answered requester.
  always_comb begin
    grant_any = 1'b0;
    grant_id  = '0;
    cand      = '0;
    for (int k = 1; k <= NREQ; k++) begin
      cand = IDW'((int'(last_grant) + k) % NREQ);
      if (!grant_any && req_valid[cand]) begin
        grant_any = 1'b1;
        grant_id  = cand;
      end
    end
  end

  assign grant_n     = req_data[{grant_id, 2'b00} +: 4];
  assign done        = eng_out_valid && !eng_out_busy;
  assign timeout     = (wdog == 5'(WDOG_LIMIT));
  assign eng_in_data = n_q;

  always_comb begin
    state_nxt    = state;
    req_ready    = '0;
    rsp_valid    = 1'b0;
    eng_in_valid = 1'b0;
    unique case (state)
      IDLE: begin
        if (grant_any) begin
          req_ready = NREQ'(1) << grant_id;
          state_nxt = (grant_n < 4'd2) ? RESP : ISSUE;
        end
      end
      ISSUE: begin
        eng_in_valid = 1'b1;
        state_nxt    = WAIT_BUSY;
      end
      // Timeout wins here: no result can be pending before busy is seen.
      WAIT_BUSY: begin
        if (timeout)           state_nxt = RESP;
        else if (eng_out_busy) state_nxt = WAIT_DONE;
      end
      WAIT_DONE: begin
        if (done || timeout) state_nxt = RESP;
      end
      RESP: begin
        rsp_valid = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    if (reset) begin
      req_ready    = '0;
      rsp_valid    = 1'b0;
      eng_in_valid = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      last_grant <= IDW'(NREQ - 1);
      id_q       <= '0;
      n_q        <= '0;
      wdog       <= '0;
      rsp_id     <= '0;
      rsp_data   <= '0;
      rsp_err    <= 1'b0;
    end else begin
      state <= state_nxt;
      unique case (state)
        IDLE: begin
          if (grant_any) begin
            id_q <= grant_id;
            n_q  <= grant_n;
            if (grant_n < 4'd2) begin
              rsp_id   <= grant_id;
              rsp_data <= 46'd1;
              rsp_err  <= 1'b0;
            end
          end
        end
        ISSUE: wdog <= '0;
        WAIT_BUSY, WAIT_DONE: begin
          if (wdog != 5'h1f) wdog <= wdog + 5'd1;
          // A real completion beats a simultaneous timeout.
          if (state == WAIT_DONE && done) begin
            rsp_id   <= id_q;
            rsp_data <= eng_out_data;
            rsp_err  <= 1'b0;
          end else if (timeout) begin
            rsp_id   <= id_q;
            rsp_data <= '0;
            rsp_err  <= 1'b1;
          end
        end
        RESP: last_grant <= rsp_id;
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_factorial_arbiter.sv
`timescale 1ns/1ps
// Bench for factorial_arbiter: directed scenarios plus random traffic scored against
// a round-robin / n! reference model, with a behavioural engine (busy for n+2 cycles).
module tb_factorial_arbiter;
  localparam int NREQ = 4;
  localparam int WDOG_LIMIT = 24;
  localparam int IDW = $clog2(NREQ);

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic [NREQ-1:0]   req_valid = '0;
  logic [NREQ*4-1:0] req_data = '0;
  logic [NREQ-1:0]   req_ready;
  logic              rsp_valid;
  logic [IDW-1:0]    rsp_id;
  logic [45:0]       rsp_data;
  logic              rsp_err;
  logic [3:0]        eng_in_data;
  logic              eng_in_valid;
  logic [45:0]       eng_out_data = '0;
  logic              eng_out_valid = 1'b0;
  logic              eng_out_busy = 1'b0;

  int errors = 0;
  int checks = 0;

  factorial_arbiter #(.NREQ(NREQ), .WDOG_LIMIT(WDOG_LIMIT)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .eng_in_data(eng_in_data), .eng_in_valid(eng_in_valid),
    .eng_out_data(eng_out_data), .eng_out_valid(eng_out_valid), .eng_out_busy(eng_out_busy)
  );

  always #5 clk = ~clk;

  function automatic logic [45:0] fact(input int n);
    longint r;
    r = 1;
    for (int k = 2; k <= n; k++) r = r * k;
    return r[45:0];
  endfunction

  // Engine: busy the cycle after start for n+2 cycles; old valid/data stay visible until the new result.
  bit         eng_dead = 1'b0;
  int         eng_cnt = 0;
  logic [3:0] eng_op = '0;
  always @(posedge clk) begin
    if (reset) begin
      eng_out_busy  <= 1'b0;
      eng_out_valid <= 1'b0;
      eng_out_data  <= '0;
      eng_cnt       <= 0;
    end else if (eng_in_valid && !eng_dead) begin
      eng_out_busy <= 1'b1;
      eng_cnt      <= int'(eng_in_data) + 2;
      eng_op       <= eng_in_data;
    end else if (eng_out_busy) begin
      eng_cnt <= eng_cnt - 1;
      if (eng_cnt == 1) begin
        eng_out_busy  <= 1'b0;
        eng_out_valid <= 1'b1;
        eng_out_data  <= fact(int'(eng_op));
      end
    end
  end

  // Observation log
  int              cyc = 0;
  int              g_id[$], g_n[$], g_cyc[$];
  logic [NREQ-1:0] g_mask[$];
  int              r_id[$], r_cyc[$];
  logic [45:0]     r_data[$];
  logic            r_err[$];
  int              starts = 0;
  logic [3:0]      start_dat = '0;
  int              ready_bad = 0;
  logic [NREQ-1:0] rel_mask = '0;

  task automatic clear_log();
    g_id.delete(); g_n.delete(); g_cyc.delete(); g_mask.delete();
    r_id.delete(); r_cyc.delete(); r_data.delete(); r_err.delete();
    starts = 0;
  endtask

  // One cycle: drop requests accepted last cycle, sample mid-cycle, advance to next negedge.
  task automatic step();
    int idx;
    idx = 0;
    #1;
    req_valid = req_valid & ~rel_mask;
    rel_mask = '0;
    #1;
    cyc++;
    if (req_ready != '0) begin
      for (int i = 0; i < NREQ; i++) if (req_ready[i]) idx = i;
      if ($countones(req_ready) != 1 || (req_ready & ~req_valid) != '0) ready_bad++;
      g_id.push_back(idx);
      g_n.push_back(int'(4'(req_data >> (4 * idx))));
      g_cyc.push_back(cyc);
      g_mask.push_back(req_valid);
      rel_mask = req_ready;
    end
    if (eng_in_valid) begin
      starts++;
      start_dat = eng_in_data;
    end
    if (rsp_valid) begin
      r_id.push_back(int'(rsp_id));
      r_data.push_back(rsp_data);
      r_err.push_back(rsp_err);
      r_cyc.push_back(cyc);
    end
    @(negedge clk);
  endtask

  task automatic post(input int i, input logic [3:0] n);
    req_valid[i] = 1'b1;
    req_data[4*i +: 4] = n;
  endtask

  task automatic run_until(input int n, input int bound);
    for (int i = 0; i < bound && r_id.size() < n; i++) step();
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    req_valid = '0;
    rel_mask = '0;
    eng_dead = 1'b0;
    repeat (3) step();
    reset = 1'b0;
    clear_log();
  endtask

  task automatic test_reset();
    req_valid = '1;
    req_data = 16'h5555;
    repeat (3) step();
    checks++; if (req_ready !== '0) begin errors++; $display("FAIL reset_req_ready: got %b want 0", req_ready); end
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid: got %b want 0", rsp_valid); end
    checks++; if (rsp_id !== '0) begin errors++; $display("FAIL reset_rsp_id: got %0d want 0", rsp_id); end
    checks++; if (rsp_data !== '0) begin errors++; $display("FAIL reset_rsp_data: got %0d want 0", rsp_data); end
    checks++; if (rsp_err !== 1'b0) begin errors++; $display("FAIL reset_rsp_err: got %b want 0", rsp_err); end
    checks++; if (eng_in_valid !== 1'b0) begin errors++; $display("FAIL reset_eng_in_valid: got %b want 0", eng_in_valid); end
    checks++; if (eng_in_data !== 4'd0) begin errors++; $display("FAIL reset_eng_in_data: got %0d want 0", eng_in_data); end
    req_valid = '0;
    reset = 1'b0;
    clear_log();
    post(2, 4'd0);
    post(0, 4'd0);
    run_until(2, 20);
    checks++; if (r_id.size() != 2) begin errors++; $display("FAIL reset_prio_count: got %0d want 2", r_id.size()); end
    else begin
      checks++; if (r_id[0] != 0) begin errors++; $display("FAIL reset_prio_first: got %0d want 0", r_id[0]); end
      checks++; if (r_id[1] != 2) begin errors++; $display("FAIL reset_prio_second: got %0d want 2", r_id[1]); end
    end
  endtask

  task automatic test_single();
    apply_reset();
    post(0, 4'd5);
    #1;
    checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL single_ready_comb: got %b want 0001", req_ready); end
    run_until(1, 60);
    checks++; if (r_id.size() != 1) begin errors++; $display("FAIL single_count: got %0d want 1", r_id.size()); end
    else begin
      checks++; if (r_id[0] != 0) begin errors++; $display("FAIL single_id: got %0d want 0", r_id[0]); end
      checks++; if (r_data[0] !== 46'd120) begin errors++; $display("FAIL single_data: got %0d want 120", r_data[0]); end
      checks++; if (r_err[0] !== 1'b0) begin errors++; $display("FAIL single_err: got %b want 0", r_err[0]); end
      checks++; if (r_cyc[0] - g_cyc[0] != 10) begin errors++; $display("FAIL single_latency: got %0d want 10", r_cyc[0] - g_cyc[0]); end
    end
    checks++; if (g_id.size() != 1) begin errors++; $display("FAIL single_grants: got %0d want 1", g_id.size()); end
    checks++; if (starts != 1 || start_dat !== 4'd5) begin errors++; $display("FAIL single_start: got %0d pulses data %0d want 1 pulse data 5", starts, start_dat); end
    repeat (5) step();
    checks++; if (r_id.size() != 1) begin errors++; $display("FAIL single_pulse_width: got %0d rsp cycles want 1", r_id.size()); end
    checks++; if (rsp_data !== 46'd120) begin errors++; $display("FAIL single_hold: got %0d want 120", rsp_data); end
  endtask

  task automatic test_same_cycle();
    apply_reset();
    post(0, 4'd3);
    post(2, 4'd4);
    run_until(2, 100);
    checks++; if (r_id.size() != 2) begin errors++; $display("FAIL pair_count: got %0d want 2", r_id.size()); end
    else begin
      checks++; if (r_id[0] != 0 || r_data[0] !== 46'd6) begin errors++; $display("FAIL pair_first: got id %0d data %0d want id 0 data 6", r_id[0], r_data[0]); end
      checks++; if (r_id[1] != 2 || r_data[1] !== 46'd24) begin errors++; $display("FAIL pair_second: got id %0d data %0d want id 2 data 24", r_id[1], r_data[1]); end
      checks++; if (r_err[0] !== 1'b0 || r_err[1] !== 1'b0) begin errors++; $display("FAIL pair_err: got %b%b want 00", r_err[0], r_err[1]); end
    end
    checks++; if (g_id.size() != 2 || starts != 2) begin errors++; $display("FAIL pair_grants: got %0d grants %0d starts want 2 and 2", g_id.size(), starts); end
  endtask

  task automatic test_bypass();
    apply_reset();
    post(1, 4'd0);
    run_until(1, 20);
    post(3, 4'd1);
    run_until(2, 20);
    checks++; if (r_id.size() != 2 || g_cyc.size() != 2) begin errors++; $display("FAIL bypass_count: got %0d rsp %0d grants want 2", r_id.size(), g_cyc.size()); end
    else begin
      for (int j = 0; j < 2; j++) begin
        checks++; if (r_data[j] !== 46'd1 || r_err[j] !== 1'b0) begin errors++; $display("FAIL bypass_data%0d: got %0d err %b want 1 err 0", j, r_data[j], r_err[j]); end
        checks++; if (r_cyc[j] - g_cyc[j] != 1) begin errors++; $display("FAIL bypass_latency%0d: got %0d want 1", j, r_cyc[j] - g_cyc[j]); end
      end
      checks++; if (r_id[0] != 1 || r_id[1] != 3) begin errors++; $display("FAIL bypass_ids: got %0d,%0d want 1,3", r_id[0], r_id[1]); end
    end
    checks++; if (starts != 0) begin errors++; $display("FAIL bypass_no_start: got %0d starts want 0", starts); end
  endtask

  task automatic test_n15();
    apply_reset();
    post(3, 4'd15);
    run_until(1, 60);
    checks++; if (r_id.size() != 1) begin errors++; $display("FAIL n15_count: got %0d want 1", r_id.size()); end
    else begin
      checks++; if (r_id[0] != 3 || r_data[0] !== 46'd1307674368000 || r_err[0] !== 1'b0)
        begin errors++; $display("FAIL n15_rsp: got id %0d data %0d err %b want id 3 data 1307674368000 err 0", r_id[0], r_data[0], r_err[0]); end
      checks++; if (r_cyc[0] - g_cyc[0] != 20) begin errors++; $display("FAIL n15_latency: got %0d want 20", r_cyc[0] - g_cyc[0]); end
    end
  endtask

  task automatic test_timeout();
    apply_reset();
    eng_dead = 1'b1;
    post(2, 4'd9);
    run_until(1, 80);
    // ISSUE, then watchdog counts 0..WDOG_LIMIT in WAIT_BUSY, then RESP.
    checks++; if (r_id.size() != 1) begin errors++; $display("FAIL timeout_count: got %0d want 1", r_id.size()); end
    else begin
      checks++; if (r_id[0] != 2 || r_data[0] !== '0 || r_err[0] !== 1'b1)
        begin errors++; $display("FAIL timeout_rsp: got id %0d data %0d err %b want id 2 data 0 err 1", r_id[0], r_data[0], r_err[0]); end
      checks++; if (r_cyc[0] - g_cyc[0] != WDOG_LIMIT + 3) begin errors++; $display("FAIL timeout_latency: got %0d want %0d", r_cyc[0] - g_cyc[0], WDOG_LIMIT + 3); end
    end
    eng_dead = 1'b0;
    post(1, 4'd4);
    run_until(2, 60);
    checks++; if (r_id.size() != 2) begin errors++; $display("FAIL timeout_recover_count: got %0d want 2", r_id.size()); end
    else begin
      checks++; if (r_id[1] != 1 || r_data[1] !== 46'd24 || r_err[1] !== 1'b0)
        begin errors++; $display("FAIL timeout_recover: got id %0d data %0d err %b want id 1 data 24 err 0", r_id[1], r_data[1], r_err[1]); end
    end
  endtask

  task automatic test_reset_midflight();
    apply_reset();
    post(1, 4'd2);
    run_until(1, 30);
    clear_log();
    post(2, 4'd6);
    for (int i = 0; i < 10 && g_id.size() == 0; i++) step();
    repeat (3) step();
    post(1, 4'd3);
    post(3, 4'd3);
    reset = 1'b1;
    step();
    checks++; if (req_ready !== '0 || rsp_valid !== 1'b0 || eng_in_valid !== 1'b0)
      begin errors++; $display("FAIL midreset_strobes: got ready %b rsp %b eng %b want 0", req_ready, rsp_valid, eng_in_valid); end
    checks++; if (rsp_id !== '0 || rsp_data !== '0 || rsp_err !== 1'b0 || eng_in_data !== 4'd0)
      begin errors++; $display("FAIL midreset_regs: got id %0d data %0d err %b eng %0d want 0", rsp_id, rsp_data, rsp_err, eng_in_data); end
    reset = 1'b0;
    run_until(2, 80);
    checks++; if (r_id.size() != 2 || g_id.size() != 3) begin errors++; $display("FAIL midreset_count: got %0d rsp %0d grants want 2 and 3", r_id.size(), g_id.size()); end
    else begin
      checks++; if (g_id[1] != 1) begin errors++; $display("FAIL midreset_grant: got %0d want 1", g_id[1]); end
      checks++; if (r_id[0] != 1 || r_data[0] !== 46'd6) begin errors++; $display("FAIL midreset_first_rsp: got id %0d data %0d want id 1 data 6", r_id[0], r_data[0]); end
      checks++; if (r_id[1] != 3) begin errors++; $display("FAIL midreset_second_rsp: got %0d want 3", r_id[1]); end
    end
  endtask

  task automatic test_random();
    int prev, exp_id, exp_lat, cand;
    apply_reset();
    for (int c = 0; c < 1500; c++) begin
      for (int i = 0; i < NREQ; i++)
        if (!req_valid[i] && $urandom_range(0, 5) == 0) post(i, 4'($urandom_range(0, 15)));
      step();
    end
    for (int i = 0; i < 600 && (req_valid != '0 || r_id.size() < g_id.size()); i++) step();
    checks++; if (r_id.size() != g_id.size() || g_id.size() < 20)
      begin errors++; $display("FAIL rand_count: got %0d rsp for %0d grants", r_id.size(), g_id.size()); end
    else begin
      for (int j = 0; j < g_id.size(); j++) begin
        prev = (j == 0) ? NREQ - 1 : g_id[j-1];
        exp_id = -1;
        for (int k = 1; k <= NREQ; k++) begin
          cand = (prev + k) % NREQ;
          if (exp_id < 0 && g_mask[j][cand]) exp_id = cand;
        end
        exp_lat = (g_n[j] < 2) ? 1 : g_n[j] + 5;
        checks++; if (g_id[j] != exp_id) begin errors++; $display("FAIL rand_rr[%0d]: got %0d want %0d", j, g_id[j], exp_id); end
        checks++; if (r_id[j] != g_id[j] || r_data[j] !== fact(g_n[j]) || r_err[j] !== 1'b0)
          begin errors++; $display("FAIL rand_rsp[%0d]: got id %0d data %0d err %b want id %0d data %0d err 0", j, r_id[j], r_data[j], r_err[j], g_id[j], fact(g_n[j])); end
        checks++; if (r_cyc[j] - g_cyc[j] != exp_lat) begin errors++; $display("FAIL rand_latency[%0d]: got %0d want %0d", j, r_cyc[j] - g_cyc[j], exp_lat); end
      end
    end
    checks++; if (ready_bad != 0) begin errors++; $display("FAIL ready_onehot: got %0d bad cycles want 0", ready_bad); end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_single();
    test_same_cycle();
    test_bypass();
    test_n15();
    test_timeout();
    test_reset_midflight();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end
endmodule
